store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 154 +++++++++++++++
 tb/tb_store_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue that drains committed stores to the bus
// and merges buffered store bytes into load data.
package store_buffer_pkg;
  localparam int ROB_ID_WIDTH = 6;
  localparam int COMMIT_WIDTH = 2;
  typedef struct packed {
    logic                                      enable;
    logic                                      flush;
    logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0] committed_rob_id;
    logic [COMMIT_WIDTH-1:0]                   committed_rob_id_valid;
  } commit_feedback_pack_t;
endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int STORE_BUFFER_SIZE = 16,
  parameter int ADDR_WIDTH        = 32,
  parameter int SIZE_WIDTH        = 2,
  parameter int BUS_DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
  input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
  input  logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
  input  logic                      exlsu_stbuf_push,
  output logic                      stbuf_exlsu_full,
  input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr,
  input  logic                      exlsu_stbuf_read_req,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
  output logic                      stbuf_exlsu_bus_ready,
  input  commit_feedback_pack_t     commit_feedback_pack,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  output logic                      stbuf_bus_read_req,
  input  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_data,
  input  logic                      bus_stbuf_read_ack,
  output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [BUS_DATA_WIDTH-1:0] stbuf_bus_write_data,
  output logic                      stbuf_bus_write_req,
  input  logic                      bus_stbuf_write_ack
);
  localparam int N  = STORE_BUFFER_SIZE;
  localparam int PW = $clog2(N);
  typedef logic [PW:0] ptr_t;

  ptr_t                      head_q, head_d, tail_q, tail_d, flush_tail;
  logic [N-1:0]              valid_q, valid_d, committed_q, committed_d;
  logic [ROB_ID_WIDTH-1:0]   rob_q [N], rob_d [N];
  logic [ADDR_WIDTH-1:0]     addr_q [N], addr_d [N];
  logic [SIZE_WIDTH-1:0]     size_q [N], size_d [N];
  logic [BUS_DATA_WIDTH-1:0] data_q [N], data_d [N];
  logic [PW-1:0]             idx, fwd_idx;
  logic [BUS_DATA_WIDTH-1:0] fwd_sh;
  logic [3:0]                fwd_mask;
  logic                      flush_en, pop, unused_ok;

  wire [PW-1:0] head_i = head_q[PW-1:0];
  wire [PW-1:0] tail_i = tail_q[PW-1:0];

  assign stbuf_exlsu_full      = (head_i == tail_i) && (head_q[PW] != tail_q[PW]);
  assign stbuf_bus_write_req   = valid_q[head_i] && committed_q[head_i];
  assign stbuf_bus_write_addr  = addr_q[head_i];
  assign stbuf_bus_write_size  = size_q[head_i];
  assign stbuf_bus_write_data  = data_q[head_i];
  assign stbuf_bus_read_addr   = {exlsu_stbuf_read_addr[ADDR_WIDTH-1:2], 2'b00};
  assign stbuf_bus_read_req    = exlsu_stbuf_read_req;
  assign stbuf_exlsu_bus_ready = bus_stbuf_read_ack;
  assign stbuf_exlsu_bus_data  = bus_stbuf_data;
  assign unused_ok             = ^exlsu_stbuf_read_addr[1:0];
  assign flush_en              = commit_feedback_pack.enable && commit_feedback_pack.flush;
  assign pop                   = stbuf_bus_write_req && bus_stbuf_write_ack;

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    rob_d       = rob_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    flush_tail  = head_q;
    idx         = '0;
    for (int i = 0; i < N; i++)
      for (int l = 0; l < COMMIT_WIDTH; l++)
        if (commit_feedback_pack.enable && valid_q[i] && commit_feedback_pack.committed_rob_id_valid[l] &&
            rob_q[i] == commit_feedback_pack.committed_rob_id[l])
          committed_d[i] = 1'b1;
    // Flush keeps everything up to the youngest committed entry, counted from head.
    for (int i = 0; i < N; i++) begin
      idx = head_i + PW'(i);
      if (valid_q[idx] && committed_d[idx]) flush_tail = head_q + ptr_t'(i + 1);
    end
    if (pop) begin
      valid_d[head_i]     = 1'b0;
      committed_d[head_i] = 1'b0;
      head_d              = head_q + ptr_t'(1);
    end
    if (flush_en) begin
      valid_d = valid_d & committed_d;
      tail_d  = flush_tail;
    end else if (exlsu_stbuf_push && !stbuf_exlsu_full) begin
      valid_d[tail_i]     = 1'b1;
      committed_d[tail_i] = 1'b0;
      rob_d[tail_i]       = exlsu_stbuf_rob_id;
      addr_d[tail_i]      = exlsu_stbuf_write_addr;
      size_d[tail_i]      = exlsu_stbuf_write_size;
      data_d[tail_i]      = exlsu_stbuf_write_data;
      tail_d              = tail_q + ptr_t'(1);
    end
  end

  // Oldest to youngest so the youngest store owns each byte lane.
  always_comb begin
    stbuf_exlsu_bus_data_feedback = bus_stbuf_data;
    fwd_idx  = '0;
    fwd_sh   = '0;
    fwd_mask = '0;
    for (int i = 0; i < N; i++) begin
      fwd_idx = head_i + PW'(i);
      if (valid_q[fwd_idx] && addr_q[fwd_idx][ADDR_WIDTH-1:2] == exlsu_stbuf_read_addr[ADDR_WIDTH-1:2]) begin
        fwd_sh   = data_q[fwd_idx] << {addr_q[fwd_idx][1:0], 3'b000};
        fwd_mask = (size_q[fwd_idx][1] ? 4'b1111 : size_q[fwd_idx][0] ? 4'b0011 : 4'b0001) << addr_q[fwd_idx][1:0];
        for (int b = 0; b < 4; b++)
          if (fwd_mask[b]) stbuf_exlsu_bus_data_feedback[8*b +: 8] = fwd_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      committed_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
    end
  end

  always_ff @(posedge clk) begin
    rob_q  <= rob_d;
    addr_q <= addr_d;
    size_q <= size_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors with hand-computed expectations for store_buffer.
module tb_store_buffer;
  import store_buffer_pkg::*;
  logic                    clk = 1'b0, rst = 1'b1;
  logic [ROB_ID_WIDTH-1:0] rob_id = '0;
  logic [31:0]             waddr = '0, wdata = '0, raddr = '0, bus_data = '0;
  logic [1:0]              wsize = '0;
  logic                    push = 1'b0, rreq = 1'b0, rack = 1'b0, wack = 1'b0;
  commit_feedback_pack_t   cfp = '0;
  logic                    full, ready, rd_req, wr_req;
  logic [31:0]             out_bus, out_fb, rd_addr, wr_addr, wr_data;
  logic [1:0]              wr_size;
  int                      total = 0, bad = 0;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .exlsu_stbuf_rob_id(rob_id), .exlsu_stbuf_write_addr(waddr), .exlsu_stbuf_write_size(wsize),
    .exlsu_stbuf_write_data(wdata), .exlsu_stbuf_push(push), .stbuf_exlsu_full(full),
    .exlsu_stbuf_read_addr(raddr), .exlsu_stbuf_read_req(rreq), .stbuf_exlsu_bus_data(out_bus),
    .stbuf_exlsu_bus_data_feedback(out_fb), .stbuf_exlsu_bus_ready(ready),
    .commit_feedback_pack(cfp), .stbuf_bus_read_addr(rd_addr), .stbuf_bus_read_req(rd_req),
    .bus_stbuf_data(bus_data), .bus_stbuf_read_ack(rack), .stbuf_bus_write_addr(wr_addr),
    .stbuf_bus_write_size(wr_size), .stbuf_bus_write_data(wr_data), .stbuf_bus_write_req(wr_req),
    .bus_stbuf_write_ack(wack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input int r, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    push = 1'b1; rob_id = ROB_ID_WIDTH'(r); waddr = a; wsize = s; wdata = d;
    tick();
    push = 1'b0;
  endtask

  task automatic commit(input int r0, input logic v0, input int r1, input logic v1);
    cfp = '0;
    cfp.enable = 1'b1;
    cfp.committed_rob_id[0] = ROB_ID_WIDTH'(r0);
    cfp.committed_rob_id[1] = ROB_ID_WIDTH'(r1);
    cfp.committed_rob_id_valid = {v1, v0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wreq", 32'(wr_req), 32'd0);

    push_st(7, 32'haaccbeef, 2'b01, 32'hdeadbeef);
    chk("uncommitted_full", 32'(full), 32'd0);
    chk("uncommitted_wreq", 32'(wr_req), 32'd0);
    commit(7, 1'b1, 0, 1'b0);
    tick();
    cfp = '0;
    for (int c = 0; c < 3; c++) begin
      chk("hold_wreq", 32'(wr_req), 32'd1);
      chk("hold_waddr", wr_addr, 32'haaccbeef);
      chk("hold_wsize", 32'(wr_size), 32'd1);
      chk("hold_wdata", wr_data, 32'hdeadbeef);
      tick();
    end
    wack = 1'b1;
    tick();
    wack = 1'b0;
    chk("popped_wreq", 32'(wr_req), 32'd0);

    for (int i = 0; i < 16; i++) push_st(10 + i, 32'h2000 + 32'(4 * i), 2'b10, 32'(i));
    chk("fill_full", 32'(full), 32'd1);
    push_st(40, 32'h5000, 2'b10, 32'h77);
    chk("push17_full", 32'(full), 32'd1);
    raddr = 32'h5000;
    bus_data = 32'h0;
    #1 chk("push17_not_stored", out_fb, 32'h0);
    commit(10, 1'b1, 0, 1'b0);
    wack = 1'b1;
    push_st(41, 32'h6000, 2'b10, 32'h88);
    cfp = '0;
    wack = 1'b0;
    chk("commit_ack_push_full", 32'(full), 32'd1);
    chk("oldest_wreq", 32'(wr_req), 32'd1);
    chk("oldest_waddr", wr_addr, 32'h2000);
    wack = 1'b1;
    push_st(42, 32'h6000, 2'b10, 32'h88);
    wack = 1'b0;
    chk("pop_full_push_ign", 32'(full), 32'd0);
    chk("next_uncommitted", 32'(wr_req), 32'd0);
    push_st(43, 32'h6004, 2'b10, 32'h99);
    chk("refill_full", 32'(full), 32'd1);

    do_reset();
    push_st(1, 32'h1003, 2'b00, 32'hab);
    push_st(2, 32'h1000, 2'b01, 32'h1234);
    rreq = 1'b1; rack = 1'b1; raddr = 32'h1000; bus_data = 32'hdace1557;
    #1;
    chk("fwd_merge", out_fb, 32'habce1234);
    chk("fwd_raw", out_bus, 32'hdace1557);
    chk("fwd_ready", 32'(ready), 32'd1);
    chk("fwd_rreq", 32'(rd_req), 32'd1);
    push_st(3, 32'h1000, 2'b10, 32'h11223344);
    push_st(4, 32'h1001, 2'b00, 32'h55);
    raddr = 32'h1002;
    #1;
    chk("fwd_youngest", out_fb, 32'h11225544);
    chk("rd_addr_align", rd_addr, 32'h1000);
    raddr = 32'h1004;
    push = 1'b1; rob_id = 5; waddr = 32'h1004; wsize = 2'b00; wdata = 32'hff;
    #1 chk("fwd_no_same_cycle", out_fb, 32'hdace1557);
    tick();
    push = 1'b0;
    chk("fwd_after_push", out_fb, 32'hdace15ff);
    rreq = 1'b0; rack = 1'b0;
    chk("rready_low", 32'(ready), 32'd0);

    do_reset();
    push_st(1, 32'h3000, 2'b10, 32'ha1);
    push_st(2, 32'h3004, 2'b10, 32'ha2);
    push_st(3, 32'h3008, 2'b10, 32'ha3);
    commit(1, 1'b1, 0, 1'b0);
    tick();
    cfp = '0; cfp.enable = 1'b1; cfp.flush = 1'b1;
    push_st(4, 32'h300c, 2'b10, 32'ha4);
    cfp = '0;
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_wreq", 32'(wr_req), 32'd1);
    chk("flush_waddr", wr_addr, 32'h3000);
    bus_data = 32'h0; raddr = 32'h3004;
    #1 chk("flush_cleared", out_fb, 32'h0);
    raddr = 32'h300c;
    #1 chk("flush_push_drop", out_fb, 32'h0);
    wack = 1'b1;
    tick();
    wack = 1'b0;
    chk("flush_drained", 32'(wr_req), 32'd0);
    push_st(5, 32'h3010, 2'b10, 32'ha5);
    push_st(6, 32'h3014, 2'b10, 32'ha6);
    raddr = 32'h3010;
    #1 chk("tail_after_flush", out_fb, 32'ha5);

    do_reset();
    push_st(8, 32'h4000, 2'b10, 32'hb8);
    push_st(9, 32'h4004, 2'b10, 32'hb9);
    commit(8, 1'b1, 9, 1'b1);
    tick();
    cfp = '0;
    wack = 1'b1;
    tick();
    wack = 1'b0;
    chk("lane1_wreq", 32'(wr_req), 32'd1);
    chk("lane1_waddr", wr_addr, 32'h4004);
    rst = 1'b1; wack = 1'b1;
    push_st(10, 32'h4008, 2'b10, 32'hba);
    rst = 1'b0; wack = 1'b0;
    chk("rst_pend_wreq", 32'(wr_req), 32'd0);
    chk("rst_pend_full", 32'(full), 32'd0);
    raddr = 32'h4004; bus_data = 32'h12345678;
    #1 chk("rst_pend_empty", out_fb, 32'h12345678);
    raddr = 32'h4008;
    #1 chk("rst_push_drop", out_fb, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
